// File: rtl/riscv_mc_controller.sv
// Main FSM plus ALU and immediate decoders for a multicycle RV32I core sharing one ALU and one memory.
// Optional macro MC_BNE_EN: accept bne (funct3 001) through the branch state with an inverted Zero test.
module riscv_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       retire,
    output logic       illegal_instr
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       branch_ok;
    logic       branch_ne;
    logic       pc_write_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       retire_raw;
    logic       illegal_raw;

    // Which branch flavours the decoder accepts; anything else on the branch opcode is illegal.
    always_comb begin
        branch_ok = (funct3 == 3'b000);
        branch_ne = 1'b0;
`ifdef MC_BNE_EN
        if (funct3 == 3'b001) begin
            branch_ok = 1'b1;
            branch_ne = 1'b1;
        end
`endif
    end

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = branch_ok ? S_BEQ : S_FETCH;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Moore-style decode of the current state; only the memory handshake and Zero feed through.
    always_comb begin
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        retire_raw    = 1'b0;
        illegal_raw   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = 2'b00;
        case (state)
            S_FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL: illegal_raw = 1'b0;
                    OP_BRANCH: illegal_raw = ~branch_ok;
                    default:   illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                retire_raw    = mem_ready;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA      = 2'b10;
                alu_op       = 2'b01;
                pc_write_raw = branch_ne ? ~Zero : Zero;
                retire_raw   = 1'b1;
            end
            S_JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked while reset is low; selects already show FETCH values because state is forced.
    assign PCWrite       = reset & pc_write_raw;
    assign MemWrite      = reset & mem_write_raw;
    assign IRWrite       = reset & ir_write_raw;
    assign RegWrite      = reset & reg_write_raw;
    assign retire        = reset & retire_raw;
    assign illegal_instr = reset & illegal_raw;

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

endmodule
